// File: rtl/itcm_arbiter.sv
// Shares the single-port, combinational-read ITCM between the IFU fetch path and the LSU read path.
// Optional macro ITCM_ARB_RANGE_CHK_EN flags LSU reads at or beyond ITCM_SIZE as errors.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module itcm_arbiter #(
   parameter int          STARVE_MAX = 4,
   parameter logic [31:0] ITCM_SIZE  = 32'h0000_1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ifu_i_req_valid,
   input  logic [`PC_SIZE-1:0]  ifu_i_req_addr,
   output logic                 ifu_o_req_ready,
   output logic                 ifu_o_rsp_valid,
   output logic [`XLEN-1:0]     ifu_o_rsp_data,
   input  logic                 ifu_i_rsp_ready,
   input  logic                 ifu_i_flush,
   input  logic                 lsu_i_req_valid,
   input  logic [`PC_SIZE-1:0]  lsu_i_req_addr,
   output logic                 lsu_o_req_ready,
   output logic                 lsu_o_rsp_valid,
   output logic [`XLEN-1:0]     lsu_o_rsp_data,
   output logic                 lsu_o_rsp_err,
   input  logic                 lsu_i_rsp_ready,
   output logic [`PC_SIZE-1:0]  itcm_o_addr,
   input  logic [`XLEN-1:0]     itcm_i_rdata
);

   // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
   // Request ready may depend on request valid; valid never depends on ready.
   typedef enum logic [1:0] {IDLE, RSP_IFU, RSP_LSU} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t              state;
   logic [`PC_SIZE-1:0] addr_r;
   logic [3:0]          starve_cnt;
   logic                ifu_rsp_vld;
   logic                lsu_rsp_vld;
   logic                lsu_err;
   logic                slot_open;
   logic                ifu_win;
   logic                lsu_win;

   assign ifu_rsp_vld = (state == RSP_IFU) && !ifu_i_flush;
   assign lsu_rsp_vld = (state == RSP_LSU);

   // A flushed IFU response frees the slot without a handshake.
   assign slot_open = rst_n &&
                      ((state == IDLE) ||
                       ((state == RSP_IFU) && (ifu_i_flush || ifu_i_rsp_ready)) ||
                       ((state == RSP_LSU) && lsu_i_rsp_ready));

   assign ifu_win = slot_open && ifu_i_req_valid &&
                    (!lsu_i_req_valid || (starve_cnt == STARVE_LIM));
   assign lsu_win = slot_open && lsu_i_req_valid && !ifu_win;

   assign ifu_o_req_ready = ifu_win;
   assign lsu_o_req_ready = lsu_win;
   assign ifu_o_rsp_valid = ifu_rsp_vld;
   assign lsu_o_rsp_valid = lsu_rsp_vld;
   assign itcm_o_addr     = addr_r;
   assign ifu_o_rsp_data  = ifu_rsp_vld ? itcm_i_rdata : '0;
   assign lsu_o_rsp_data  = (lsu_rsp_vld && !lsu_err) ? itcm_i_rdata : '0;
   assign lsu_o_rsp_err   = lsu_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_r     <= '0;
         starve_cnt <= '0;
      end else begin
         if (slot_open) begin
            if (lsu_win) begin
               state  <= RSP_LSU;
               addr_r <= lsu_i_req_addr;
            end else if (ifu_win) begin
               state  <= RSP_IFU;
               addr_r <= ifu_i_req_addr;
            end else begin
               state  <= IDLE;
            end
         end
         if (!ifu_i_req_valid || ifu_win) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

`ifdef ITCM_ARB_RANGE_CHK_EN
   // Out-of-range flag is captured with the grant so it stays aligned with addr_r.
   logic err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (lsu_win) begin
         err_r <= ({32'd0, lsu_i_req_addr} >= {`PC_SIZE'd0, ITCM_SIZE});
      end
   end

   assign lsu_err = lsu_rsp_vld && err_r;
`else
   wire unused_itcm_size = ^ITCM_SIZE;

   assign lsu_err = 1'b0;
`endif

endmodule

// File: tb/tb_itcm_arbiter.sv
// Directed, table-driven bench for itcm_arbiter with a behavioural ITCM word model.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_itcm_arbiter;

`ifdef ITCM_ARB_RANGE_CHK_EN
   localparam logic RANGE_ON = 1'b1;
`else
   localparam logic RANGE_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        ifu_i_req_valid;
   logic [31:0] ifu_i_req_addr;
   logic        ifu_o_req_ready;
   logic        ifu_o_rsp_valid;
   logic [31:0] ifu_o_rsp_data;
   logic        ifu_i_rsp_ready;
   logic        ifu_i_flush;
   logic        lsu_i_req_valid;
   logic [31:0] lsu_i_req_addr;
   logic        lsu_o_req_ready;
   logic        lsu_o_rsp_valid;
   logic [31:0] lsu_o_rsp_data;
   logic        lsu_o_rsp_err;
   logic        lsu_i_rsp_ready;
   logic [31:0] itcm_o_addr;
   logic [31:0] itcm_i_rdata;

   int checks;
   int errors;

   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        irr;
      logic        fl;
      logic        lv;
      logic [31:0] la;
      logic        lrr;
      logic        e_ir;
      logic        e_lr;
      logic        e_irv;
      logic        e_lrv;
      logic [31:0] e_addr;
      logic        e_err;
   } vec_t;

   vec_t vecs[24];

   itcm_arbiter #(.STARVE_MAX(4), .ITCM_SIZE(32'h0000_1000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ifu_i_req_valid (ifu_i_req_valid),
      .ifu_i_req_addr  (ifu_i_req_addr),
      .ifu_o_req_ready (ifu_o_req_ready),
      .ifu_o_rsp_valid (ifu_o_rsp_valid),
      .ifu_o_rsp_data  (ifu_o_rsp_data),
      .ifu_i_rsp_ready (ifu_i_rsp_ready),
      .ifu_i_flush     (ifu_i_flush),
      .lsu_i_req_valid (lsu_i_req_valid),
      .lsu_i_req_addr  (lsu_i_req_addr),
      .lsu_o_req_ready (lsu_o_req_ready),
      .lsu_o_rsp_valid (lsu_o_rsp_valid),
      .lsu_o_rsp_data  (lsu_o_rsp_data),
      .lsu_o_rsp_err   (lsu_o_rsp_err),
      .lsu_i_rsp_ready (lsu_i_rsp_ready),
      .itcm_o_addr     (itcm_o_addr),
      .itcm_i_rdata    (itcm_i_rdata)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ITCM model: every address maps to a distinct word
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   assign itcm_i_rdata = word_of(itcm_o_addr);

   function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic irr,
                               input logic fl, input logic lv, input logic [31:0] la,
                               input logic lrr, input logic e_ir, input logic e_lr,
                               input logic e_irv, input logic e_lrv,
                               input logic [31:0] e_addr, input logic e_err);
      vec_t v;
      v.iv = iv; v.ia = ia; v.irr = irr; v.fl = fl;
      v.lv = lv; v.la = la; v.lrr = lrr;
      v.e_ir = e_ir; v.e_lr = e_lr; v.e_irv = e_irv; v.e_lrv = e_lrv;
      v.e_addr = e_addr; v.e_err = e_err;
      return v;
   endfunction

   // Scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic e_ir, input logic e_lr,
                                input logic e_irv, input logic e_lrv,
                                input logic [31:0] e_addr, input logic e_err);
      logic [31:0] e_idata;
      logic [31:0] e_ldata;
      e_idata = e_irv ? word_of(e_addr) : 32'd0;
      e_ldata = (e_lrv && !e_err) ? word_of(e_addr) : 32'd0;
      check({tag, ".ifu_ready"}, {31'd0, ifu_o_req_ready}, {31'd0, e_ir});
      check({tag, ".lsu_ready"}, {31'd0, lsu_o_req_ready}, {31'd0, e_lr});
      check({tag, ".ifu_rsp_valid"}, {31'd0, ifu_o_rsp_valid}, {31'd0, e_irv});
      check({tag, ".lsu_rsp_valid"}, {31'd0, lsu_o_rsp_valid}, {31'd0, e_lrv});
      check({tag, ".itcm_addr"}, itcm_o_addr, e_addr);
      check({tag, ".ifu_rsp_data"}, ifu_o_rsp_data, e_idata);
      check({tag, ".lsu_rsp_data"}, lsu_o_rsp_data, e_ldata);
      check({tag, ".lsu_rsp_err"}, {31'd0, lsu_o_rsp_err}, {31'd0, e_err && e_lrv});
   endtask

   // Driver: inputs change just after the rising edge, outputs are sampled on the falling edge
   task automatic drive(input logic iv, input logic [31:0] ia, input logic irr, input logic fl,
                        input logic lv, input logic [31:0] la, input logic lrr);
      @(posedge clk);
      #1;
      ifu_i_req_valid = iv;
      ifu_i_req_addr  = ia;
      ifu_i_rsp_ready = irr;
      ifu_i_flush     = fl;
      lsu_i_req_valid = lv;
      lsu_i_req_addr  = la;
      lsu_i_rsp_ready = lrr;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //          iv ia      irr fl lv la        lrr  ir lr irv lrv addr      err
      vecs[0]  = mk(1, 32'h0,  1, 0, 0, 32'h0,    1,   1, 0, 0, 0, 32'h0,    0);
      vecs[1]  = mk(1, 32'h4,  1, 0, 0, 32'h0,    1,   1, 0, 1, 0, 32'h0,    0);
      vecs[2]  = mk(1, 32'h8,  1, 0, 0, 32'h0,    1,   1, 0, 1, 0, 32'h4,    0);
      vecs[3]  = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 1, 0, 32'h8,    0);
      vecs[4]  = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 0, 0, 32'h8,    0);
      vecs[5]  = mk(1, 32'h20, 1, 0, 1, 32'h100,  1,   0, 1, 0, 0, 32'h8,    0);
      vecs[6]  = mk(1, 32'h20, 1, 0, 0, 32'h0,    1,   1, 0, 0, 1, 32'h100,  0);
      vecs[7]  = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 1, 0, 32'h20,   0);
      vecs[8]  = mk(0, 32'h0,  1, 0, 1, 32'h200,  0,   0, 1, 0, 0, 32'h20,   0);
      vecs[9]  = mk(1, 32'h44, 1, 0, 0, 32'h0,    0,   0, 0, 0, 1, 32'h200,  0);
      vecs[10] = mk(1, 32'h44, 1, 0, 0, 32'h0,    0,   0, 0, 0, 1, 32'h200,  0);
      vecs[11] = mk(1, 32'h44, 1, 0, 0, 32'h0,    0,   0, 0, 0, 1, 32'h200,  0);
      vecs[12] = mk(1, 32'h44, 1, 0, 0, 32'h0,    1,   1, 0, 0, 1, 32'h200,  0);
      vecs[13] = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 1, 0, 32'h44,   0);
      vecs[14] = mk(1, 32'h40, 1, 0, 0, 32'h0,    1,   1, 0, 0, 0, 32'h44,   0);
      vecs[15] = mk(1, 32'h80, 1, 1, 0, 32'h0,    1,   1, 0, 0, 0, 32'h40,   0);
      vecs[16] = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 1, 0, 32'h80,   0);
      vecs[17] = mk(1, 32'h50, 1, 0, 1, 32'h300,  1,   0, 1, 0, 0, 32'h80,   0);
      vecs[18] = mk(1, 32'h50, 1, 1, 0, 32'h0,    1,   1, 0, 0, 1, 32'h300,  0);
      vecs[19] = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 1, 0, 32'h50,   0);
      vecs[20] = mk(0, 32'h0,  1, 0, 1, 32'h1000, 1,   0, 1, 0, 0, 32'h50,   0);
      vecs[21] = mk(0, 32'h0,  1, 0, 1, 32'hFFC,  1,   0, 1, 0, 1, 32'h1000, RANGE_ON);
      vecs[22] = mk(0, 32'h0,  1, 0, 0, 32'h0,    1,   0, 0, 0, 1, 32'hFFC,  0);
      vecs[23] = mk(0, 32'h0,  1, 1, 0, 32'h0,    1,   0, 0, 0, 0, 32'hFFC,  0);

      rst_n = 1'b0;
      ifu_i_req_valid = 1'b0; ifu_i_req_addr = '0; ifu_i_rsp_ready = 1'b0; ifu_i_flush = 1'b0;
      lsu_i_req_valid = 1'b0; lsu_i_req_addr = '0; lsu_i_rsp_ready = 1'b0;
      #12;
      check_outputs("reset", 0, 0, 0, 0, 32'h0, 0);
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].iv, vecs[i].ia, vecs[i].irr, vecs[i].fl,
               vecs[i].lv, vecs[i].la, vecs[i].lrr);
         check_outputs($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_lr,
                       vecs[i].e_irv, vecs[i].e_lrv, vecs[i].e_addr, vecs[i].e_err);
      end

      // Both requesters saturated: the IFU must win every fifth grant slot
      for (int i = 0; i < 10; i++) begin
         logic        ifu_turn;
         logic        prev_ifu;
         logic [31:0] e_addr;
         ifu_turn = ((i % 5) == 4);
         prev_ifu = (i > 0) && (((i - 1) % 5) == 4);
         e_addr   = (i == 0) ? 32'hFFC : (prev_ifu ? 32'h60 : 32'h400);
         drive(1, 32'h60, 1, 0, 1, 32'h400, 1);
         check_outputs($sformatf("starve%0d", i), ifu_turn, !ifu_turn,
                       prev_ifu, (i > 0) && !prev_ifu, e_addr, 0);
      end
      drive(0, 32'h0, 1, 0, 0, 32'h0, 1);
      check_outputs("starve_drain", 0, 0, 1, 0, 32'h60, 0);
      drive(0, 32'h0, 1, 0, 0, 32'h0, 1);
      check_outputs("starve_idle", 0, 0, 0, 0, 32'h60, 0);

      // Reset while an LSU response is outstanding
      drive(0, 32'h0, 1, 0, 1, 32'h500, 0);
      check_outputs("rst_grant", 0, 1, 0, 0, 32'h60, 0);
      drive(0, 32'h0, 1, 0, 1, 32'h504, 0);
      check_outputs("rst_pending", 0, 0, 0, 1, 32'h500, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("rst_async", 0, 0, 0, 0, 32'h0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      lsu_i_req_valid = 1'b0;
      lsu_i_rsp_ready = 1'b1;
      @(negedge clk);
      check_outputs("rst_hold", 0, 0, 0, 0, 32'h0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'h0, 1, 0, 0, 32'h0, 1);
         check_outputs($sformatf("post_rst%0d", i), 0, 0, 0, 0, 32'h0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/itcm_arbiter.md
Name: itcm_arbiter

Overview:
- Sequences and shares the single-port, combinational-read instruction TCM (otp4k8) between two requesters: the IFU instruction fetch path and the LSU data-read path (loads of constants/tables from ITCM).
- Sits between the IFU and the ITCM, and between the LSU and the ITCM.
- Serializes accesses with valid/ready handshakes, holds the ITCM address stable for the response cycle, and guarantees forward progress for the IFU under LSU pressure.

Parameters:
- STARVE_MAX, 4, number of consecutive denied IFU request cycles after which the IFU is force-granted (range 1..15).
- ITCM_SIZE, 32'h0000_1000, ITCM size in bytes; used only by the optional range check.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- ifu_i_req_valid  input  1  IFU fetch request
- ifu_i_req_addr  input  `PC_SIZE  IFU fetch byte address
- ifu_o_req_ready  output  1  IFU request accepted this cycle
- ifu_o_rsp_valid  output  1  IFU response data valid
- ifu_o_rsp_data  output  `XLEN  IFU instruction word
- ifu_i_rsp_ready  input  1  IFU accepts response
- ifu_i_flush  input  1  pipe flush; discards any pending IFU response
- lsu_i_req_valid  input  1  LSU read request
- lsu_i_req_addr  input  `PC_SIZE  LSU read byte address
- lsu_o_req_ready  output  1  LSU request accepted this cycle
- lsu_o_rsp_valid  output  1  LSU response data valid
- lsu_o_rsp_data  output  `XLEN  LSU read word
- lsu_o_rsp_err  output  1  LSU access error (tied 0 without optional feature)
- lsu_i_rsp_ready  input  1  LSU accepts response
- itcm_o_addr  output  `PC_SIZE  address to ITCM (registered)
- itcm_i_rdata  input  `XLEN  ITCM combinational read data

Behaviour:
- One clock, clk; reset asynchronous, active-low, rst_n.
- Reset values:
  - state=IDLE; addr_r=0 (so itcm_o_addr=0); starve_cnt=0.
  - All *_ready, *_rsp_valid and lsu_o_rsp_err are 0.
  - Response data outputs are 0 while their rsp_valid is 0.
- States:
  - IDLE: no access outstanding.
  - RSP_IFU: IFU access outstanding.
  - RSP_LSU: LSU access outstanding.
- Only one access is outstanding at a time.
- Grant slot is open when state==IDLE, or when the current response handshakes this cycle (rsp_valid&rsp_ready), or when state==RSP_IFU and ifu_i_flush=1.
- Arbitration in an open slot:
  - LSU has fixed priority over IFU.
  - Exception: if starve_cnt==STARVE_MAX and ifu_i_req_valid, the IFU wins.
- Grant effects:
  - Winner's req_ready=1 combinationally in that cycle (ready depends on valid; valid must not depend on ready).
  - addr_r<=winner addr.
  - state<=RSP_winner.
  - If no request, state<=IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle ifu_i_req_valid=1 and the IFU is not granted.
  - Clears on IFU grant or when ifu_i_req_valid=0.
- Latency: request accepted in cycle N; rsp_valid=1 from cycle N+1.
- Response data: rsp_data=itcm_i_rdata, driven from the stable addr_r.
- Response hold: rsp_valid, rsp_data and addr_r hold until rsp_ready.
- Back-to-back: sustained throughput is one access per cycle when the consumer holds rsp_ready=1.
- Flush:
  - ifu_i_flush in RSP_IFU drops the response (ifu_o_rsp_valid forced 0 that cycle); the slot re-opens the same cycle.
  - A new IFU request with the flush target may be granted in the flush cycle.
  - Flush in RSP_LSU or IDLE has no effect on the LSU.
  - Flush in RSP_LSU does not block an IFU grant when the LSU response completes.
- Simultaneous events: rsp handshake plus a new request in the same cycle yields a new grant; no bubble.
- Address: full byte address passes through unmodified; alignment is the requester's responsibility.
- Reset mid-access: outstanding response discarded, return to reset values, no response issued after rst_n deasserts.

Optional Feature:
- Macro: ITCM_ARB_RANGE_CHK_EN.
- Defined:
  - LSU request with addr>=ITCM_SIZE is still accepted.
  - Its response has lsu_o_rsp_err=1 and lsu_o_rsp_data=0; ITCM data is ignored.
  - IFU requests are never checked.
- Undefined: no comparator; lsu_o_rsp_err tied 0; out-of-range addresses read whatever the ITCM returns.

Test Plan:
- IFU alone, addr 0x0,0x4,0x8 back-to-back with rsp_ready=1:
  - ready in cycles 1,2,3; rsp_valid in cycles 2,3,4.
  - Data equals ITCM words 0,1,2; itcm_o_addr 0x0,0x4,0x8.
- IFU and LSU both request in the same cycle (LSU addr 0x100, IFU 0x20): LSU granted first, IFU granted on the next cycle after the LSU response handshakes.
- LSU continuously valid, IFU continuously valid, STARVE_MAX=4: IFU granted in every 5th grant slot; starve_cnt returns to 0 after the IFU grant.
- IFU request 0x40 accepted, then ifu_i_flush with new request 0x80 in the response cycle:
  - No response for 0x40.
  - 0x80 accepted that cycle; response data is word 0x80 next cycle.
- LSU response with lsu_i_rsp_ready=0 for 3 cycles: rsp_valid, data and itcm_o_addr held stable; no other grant; handshake on cycle 4.
- With ITCM_ARB_RANGE_CHK_EN, LSU addr 0x1000, ITCM_SIZE=0x1000: lsu_o_rsp_err=1, data=0. Without the macro: err=0.
- Assert rst_n=0 during RSP_LSU: all outputs return to 0 asynchronously; no response after reset release.
